// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and load/store.
// One transaction in flight; request fields are captured at grant and a watchdog bounds WAIT.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LSU_PRIO = 1,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic                ifu_resp_err,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic                lsu_resp_err,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                err_stray
);

  // state | meaning
  // IDLE  | arbitrate; winner's ready is raised combinationally and its fields latched
  // REQ   | present latched request to memory until mem_req_ready
  // WAIT  | wait for mem_resp_valid; watchdog forces an error response at TIMEOUT-1

  localparam int MASK_W = DATA_W / 8;
  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t              state, state_nxt;
  logic                owner, last_grant;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [WDOG_W-1:0]   wdog;
  logic                stray_q;
  logic                accept, pick_lsu, done, done_err;

  always_comb begin
    pick_lsu  = lsu_req_valid &&
                (!ifu_req_valid || (LSU_PRIO != 0) || (last_grant == OWN_IFU));
    accept    = 1'b0;
    done      = 1'b0;
    done_err  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ifu_req_valid || lsu_req_valid) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        // a real response beats a coincident timeout
        if (mem_resp_valid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (wdog == WDOG_LAST) begin
          done      = 1'b1;
          done_err  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // gated by rst so nothing is visible while reset is held
  assign ifu_req_ready  = rst && accept && !pick_lsu;
  assign lsu_req_ready  = rst && accept && pick_lsu;
  assign ifu_resp_valid = rst && done && (owner == OWN_IFU);
  assign lsu_resp_valid = rst && done && (owner == OWN_LSU);
  assign ifu_resp_err   = ifu_resp_valid && done_err;
  assign lsu_resp_err   = lsu_resp_valid && done_err;
  assign ifu_rdata      = (ifu_resp_valid && !done_err) ? mem_rdata : '0;
  assign lsu_rdata      = (lsu_resp_valid && !done_err) ? mem_rdata : '0;

  assign mem_req_valid  = (state == REQ);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign busy           = (state != IDLE);
  assign err_stray      = stray_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_IFU;
      last_grant <= OWN_LSU;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      wdog       <= '0;
      stray_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= pick_lsu;
        last_grant <= pick_lsu;
        addr_q     <= pick_lsu ? lsu_addr : ifu_addr;
        wen_q      <= pick_lsu && lsu_wen;
        wdata_q    <= pick_lsu ? lsu_wdata : '0;
        wmask_q    <= pick_lsu ? lsu_wmask : '0;
      end
      if (state == REQ && mem_req_ready)
        wdog <= '0;
      else if (state == WAIT && wdog != WDOG_MAX)
        wdog <= wdog + WDOG_W'(1);
      if (mem_resp_valid && state != WAIT)
        stray_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 has LSU priority, instance 1 round-robin, both TIMEOUT=8.
// Responses are checked against a per-instance scoreboard filled when requests are granted.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          ifu_req_valid [2], ifu_req_ready [2], ifu_resp_valid [2], ifu_resp_err [2];
  logic [AW-1:0] ifu_addr [2];
  logic [DW-1:0] ifu_rdata [2];
  logic          lsu_req_valid [2], lsu_req_ready [2], lsu_wen [2], lsu_resp_valid [2], lsu_resp_err [2];
  logic [AW-1:0] lsu_addr [2];
  logic [DW-1:0] lsu_wdata [2], lsu_rdata [2];
  logic [MW-1:0] lsu_wmask [2];
  logic          mem_req_valid [2], mem_req_ready [2], mem_wen [2], mem_resp_valid [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wdata [2], mem_rdata [2];
  logic [MW-1:0] mem_wmask [2];
  logic          busy [2], err_stray [2];
  logic          auto_resp [2], manual_resp [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .LSU_PRIO((g == 0) ? 1 : 0), .TIMEOUT(8)
    ) u_dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid[g]), .ifu_req_ready(ifu_req_ready[g]),
      .ifu_addr(ifu_addr[g]), .ifu_resp_valid(ifu_resp_valid[g]),
      .ifu_resp_err(ifu_resp_err[g]), .ifu_rdata(ifu_rdata[g]),
      .lsu_req_valid(lsu_req_valid[g]), .lsu_req_ready(lsu_req_ready[g]),
      .lsu_addr(lsu_addr[g]), .lsu_wen(lsu_wen[g]), .lsu_wdata(lsu_wdata[g]),
      .lsu_wmask(lsu_wmask[g]), .lsu_resp_valid(lsu_resp_valid[g]),
      .lsu_resp_err(lsu_resp_err[g]), .lsu_rdata(lsu_rdata[g]),
      .mem_req_valid(mem_req_valid[g]), .mem_req_ready(mem_req_ready[g]),
      .mem_addr(mem_addr[g]), .mem_wen(mem_wen[g]), .mem_wdata(mem_wdata[g]),
      .mem_wmask(mem_wmask[g]), .mem_resp_valid(mem_resp_valid[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g]), .err_stray(err_stray[g])
    );
  end

  typedef struct packed {
    logic          lsu;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    logic          lsu;
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic          exp_wen;
    logic [MW-1:0] exp_wmask;
  } vec_t;

  exp_t sbq0[$];
  exp_t sbq1[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_8067 : (a ^ 32'hC3C3_0F0F);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) sbq0.push_back(e);
    else sbq1.push_back(e);
  endtask

  // called at a drive point; returns at a falling edge with the instance idle
  task automatic wait_idle(input int d);
    int k = 0;
    smp();
    while (busy[d] && k < 20) begin
      cyc();
      smp();
      k++;
    end
    check("wait_idle_bound", k < 20, 1);
  endtask

  task automatic run_vec(input vec_t v);
    if (v.lsu) begin
      lsu_addr[0] = v.addr; lsu_wen[0] = v.wen; lsu_wdata[0] = v.wdata; lsu_wmask[0] = v.wmask;
      lsu_req_valid[0] = 1'b1;
    end else begin
      ifu_addr[0] = v.addr;
      lsu_wen[0] = 1'b1; lsu_wmask[0] = '1; lsu_wdata[0] = ~v.addr;
      ifu_req_valid[0] = 1'b1;
    end
    smp();
    check("vec_ready", {ifu_req_ready[0], lsu_req_ready[0]}, {!v.lsu, v.lsu});
    push_exp(0, exp_t'{v.lsu, 1'b0, mem_model(v.addr)});
    cyc();
    ifu_req_valid[0] = 1'b0;
    lsu_req_valid[0] = 1'b0;
    smp();
    check("vec_mem_valid", mem_req_valid[0], 1);
    check("vec_mem_addr", mem_addr[0], v.addr);
    check("vec_mem_wen", mem_wen[0], v.exp_wen);
    check("vec_mem_wmask", mem_wmask[0], v.exp_wmask);
    if (v.lsu) check("vec_mem_wdata", mem_wdata[0], v.wdata);
    cyc();
    wait_idle(0);
    cyc();
  endtask

  // memory model: responds in the first WAIT cycle when automatic, else follows manual_resp
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int d = 0; d < 2; d++) begin
        if (auto_resp[d]) mem_resp_valid[d] = busy[d] && !mem_req_valid[d];
        else mem_resp_valid[d] = manual_resp[d];
        mem_rdata[d] = mem_resp_valid[d] ? mem_model(mem_addr[d]) : '0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (ifu_resp_valid[d] || lsu_resp_valid[d]) begin
          exp_t e;
          logic have;
          have = (d == 0) ? (sbq0.size() > 0) : (sbq1.size() > 0);
          check("sb_expected_resp", have, 1);
          if (have) begin
            if (d == 0) e = sbq0.pop_front();
            else e = sbq1.pop_front();
            check("sb_owner", {lsu_resp_valid[d], ifu_resp_valid[d]}, {e.lsu, !e.lsu});
            check("sb_err", e.lsu ? lsu_resp_err[d] : ifu_resp_err[d], e.err);
            check("sb_rdata", e.lsu ? lsu_rdata[d] : ifu_rdata[d], e.rdata);
            check("sb_other_rdata", e.lsu ? ifu_rdata[d] : lsu_rdata[d], 0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [6];
    int k;
    vecs[0] = '{1'b0, 32'h0000_1000, 1'b0, 32'h0,         4'h0, 1'b0, 4'h0};
    vecs[1] = '{1'b1, 32'h2000_0004, 1'b0, 32'hDEAD_BEEF, 4'h0, 1'b0, 4'h0};
    vecs[2] = '{1'b1, 32'h2000_0008, 1'b1, 32'h1234_5678, 4'h3, 1'b1, 4'h3};
    vecs[3] = '{1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0,         4'h0, 1'b0, 4'h0};
    vecs[4] = '{1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1, 4'hF};
    vecs[5] = '{1'b1, 32'h3000_0000, 1'b1, 32'h0000_00A5, 4'h8, 1'b1, 4'h8};

    for (int d = 0; d < 2; d++) begin
      ifu_req_valid[d] = 1'b0; ifu_addr[d] = '0;
      lsu_req_valid[d] = 1'b0; lsu_addr[d] = '0; lsu_wen[d] = 1'b0;
      lsu_wdata[d] = '0; lsu_wmask[d] = '0;
      mem_req_ready[d] = 1'b1; mem_resp_valid[d] = 1'b0; mem_rdata[d] = '0;
      auto_resp[d] = 1'b1; manual_resp[d] = 1'b0;
    end

    // reset held with requests pending: everything reads 0
    ifu_req_valid[0] = 1'b1;
    lsu_req_valid[1] = 1'b1;
    #12;
    check("rst_ifu_ready", ifu_req_ready[0], 0);
    check("rst_lsu_ready", lsu_req_ready[1], 0);
    check("rst_busy", busy[0], 0);
    check("rst_mem_valid", mem_req_valid[0], 0);
    check("rst_mem_addr", mem_addr[0], 0);
    check("rst_err_stray", err_stray[0], 0);
    ifu_req_valid[0] = 1'b0;
    lsu_req_valid[1] = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();

    // single fetch latency: accept N, request N+1, response N+2, idle N+3
    ifu_addr[0] = 32'h8000_0000;
    ifu_req_valid[0] = 1'b1;
    smp();
    check("t1_ifu_ready", ifu_req_ready[0], 1);
    check("t1_lsu_ready", lsu_req_ready[0], 0);
    push_exp(0, exp_t'{1'b0, 1'b0, 32'h0000_8067});
    cyc();
    ifu_req_valid[0] = 1'b0;
    smp();
    check("t1_mem_valid", mem_req_valid[0], 1);
    check("t1_mem_addr", mem_addr[0], 32'h8000_0000);
    check("t1_resp_early", ifu_resp_valid[0], 0);
    cyc();
    smp();
    check("t1_resp_valid", ifu_resp_valid[0], 1);
    check("t1_rdata", ifu_rdata[0], 32'h0000_8067);
    cyc();
    smp();
    check("t1_busy_after", busy[0], 0);
    cyc();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // tie with LSU priority: store wins, fetch follows three cycles later
    lsu_addr[0] = 32'h0000_0100; lsu_wen[0] = 1'b1;
    lsu_wdata[0] = 32'hAAAA_A555; lsu_wmask[0] = 4'hF;
    ifu_addr[0] = 32'h8000_0004;
    lsu_req_valid[0] = 1'b1;
    ifu_req_valid[0] = 1'b1;
    smp();
    check("t2_lsu_ready", lsu_req_ready[0], 1);
    check("t2_ifu_ready", ifu_req_ready[0], 0);
    push_exp(0, exp_t'{1'b1, 1'b0, mem_model(32'h0000_0100)});
    cyc();
    lsu_req_valid[0] = 1'b0;
    smp();
    check("t2_mem_wen", mem_wen[0], 1);
    check("t2_mem_wdata", mem_wdata[0], 32'hAAAA_A555);
    check("t2_mem_wmask", mem_wmask[0], 4'hF);
    check("t2_ifu_held", ifu_req_ready[0], 0);
    k = 0;
    while (!ifu_req_ready[0] && k < 10) begin
      cyc();
      smp();
      k++;
    end
    check("t2_ifu_grant_delay", k, 2);
    push_exp(0, exp_t'{1'b0, 1'b0, mem_model(32'h8000_0004)});
    cyc();
    ifu_req_valid[0] = 1'b0;
    wait_idle(0);
    cyc();

    // round-robin instance, both held valid: IFU, LSU, IFU, LSU
    ifu_addr[1] = 32'h0000_4000;
    lsu_addr[1] = 32'h0000_5000;
    lsu_wen[1] = 1'b0;
    ifu_req_valid[1] = 1'b1;
    lsu_req_valid[1] = 1'b1;
    for (int g = 0; g < 4; g++) begin
      int w = 0;
      smp();
      while (!(ifu_req_ready[1] || lsu_req_ready[1]) && w < 10) begin
        cyc();
        smp();
        w++;
      end
      check("t3_grant_bound", w < 10, 1);
      check("t3_rr_grant", {lsu_req_ready[1], ifu_req_ready[1]}, {(g % 2) == 1, (g % 2) == 0});
      push_exp(1, exp_t'{(g % 2) == 1, 1'b0,
                         mem_model(((g % 2) == 1) ? 32'h0000_5000 : 32'h0000_4000)});
      cyc();
    end
    ifu_req_valid[1] = 1'b0;
    lsu_req_valid[1] = 1'b0;
    wait_idle(1);
    cyc();

    // memory never answers: error response on the 8th WAIT cycle
    auto_resp[0] = 1'b0;
    manual_resp[0] = 1'b0;
    ifu_addr[0] = 32'h0000_9000;
    ifu_req_valid[0] = 1'b1;
    smp();
    check("t4_ready", ifu_req_ready[0], 1);
    push_exp(0, exp_t'{1'b0, 1'b1, 32'h0});
    cyc();
    ifu_req_valid[0] = 1'b0;
    smp();
    check("t4_mem_valid", mem_req_valid[0], 1);
    k = 0;
    do begin
      cyc();
      smp();
      k++;
    end while (!ifu_resp_valid[0] && k < 20);
    check("t4_timeout_cycles", k, 8);
    check("t4_resp_err", ifu_resp_err[0], 1);
    check("t4_busy_at_resp", busy[0], 1);
    cyc();
    smp();
    check("t4_busy_after", busy[0], 0);
    auto_resp[0] = 1'b1;
    cyc();

    // memory stalls in REQ longer than TIMEOUT: fields stable, no timeout
    mem_req_ready[0] = 1'b0;
    lsu_addr[0] = 32'hA000_0010; lsu_wen[0] = 1'b1;
    lsu_wdata[0] = 32'h0BAD_F00D; lsu_wmask[0] = 4'h5;
    lsu_req_valid[0] = 1'b1;
    smp();
    check("t5_ready", lsu_req_ready[0], 1);
    push_exp(0, exp_t'{1'b1, 1'b0, mem_model(32'hA000_0010)});
    cyc();
    lsu_req_valid[0] = 1'b0;
    lsu_addr[0] = 32'h1111_1111;
    lsu_wdata[0] = 32'h2222_2222;
    for (int i = 0; i < 10; i++) begin
      smp();
      check("t5_mem_valid", mem_req_valid[0], 1);
      check("t5_busy", busy[0], 1);
      check("t5_mem_addr", mem_addr[0], 32'hA000_0010);
      check("t5_mem_wdata", mem_wdata[0], 32'h0BAD_F00D);
      check("t5_no_resp", lsu_resp_valid[0], 0);
      cyc();
    end
    mem_req_ready[0] = 1'b1;
    wait_idle(0);
    cyc();

    // reset during WAIT, then a late response: no strobe, stray flagged
    auto_resp[0] = 1'b0;
    manual_resp[0] = 1'b0;
    ifu_addr[0] = 32'h0000_B000;
    ifu_req_valid[0] = 1'b1;
    smp();
    check("t6_ready", ifu_req_ready[0], 1);
    cyc();
    ifu_req_valid[0] = 1'b0;
    smp();
    cyc();
    smp();
    check("t6_in_wait", busy[0], 1);
    check("t6_no_stray_yet", err_stray[0], 0);
    cyc();
    rst = 1'b0;
    smp();
    check("t6_rst_busy", busy[0], 0);
    check("t6_rst_no_resp", ifu_resp_valid[0], 0);
    cyc();
    rst = 1'b1;
    manual_resp[0] = 1'b1;
    smp();
    check("t6_late_ifu_resp", ifu_resp_valid[0], 0);
    check("t6_late_lsu_resp", lsu_resp_valid[0], 0);
    check("t6_late_rdata", ifu_rdata[0], 0);
    cyc();
    manual_resp[0] = 1'b0;
    smp();
    check("t6_err_stray", err_stray[0], 1);
    check("t6_idle", busy[0], 0);
    check("rr_inst_no_stray", err_stray[1], 0);
    cyc();
    cyc();

    check("sb0_drained", sbq0.size(), 0);
    check("sb1_drained", sbq1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
